// File: rtl/down_timer.sv
// down_timer: programmable down-counting timer with valid/ready load,
// one-shot or auto-reload operation, pause/abort, a one-cycle terminal-count
// pulse (tc) and a sticky done flag.
// Optional feature macro: DOWN_TIMER_PRESCALE_EN -- when defined, the count
// decrements once every PRESCALE clock cycles spent in RUN instead of every cycle.
module down_timer #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic             mode_reg;
  logic             tick;

`ifdef DOWN_TIMER_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;

  // Decrement enable: prescaler has reached its last phase
  assign tick = (presc == PW'(PRESCALE - 1));
`else
  logic unused_prescale;

  // Decrement on every RUN cycle; the prescale parameter has no role here
  assign tick            = 1'b1;
  assign unused_prescale = (PRESCALE < 2);
`endif

  // Timer FSM: state, count, reload/mode registers and registered flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      mode_reg   <= 1'b0;
      tc         <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      load_ready <= 1'b1;
`ifdef DOWN_TIMER_PRESCALE_EN
      presc      <= '0;
`endif
    end else begin
      tc <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (load_valid) begin
            // Load beats start; landing in IDLE clears a sticky done
            reload_reg <= load_value;
            count      <= load_value;
            state      <= IDLE;
            done       <= 1'b0;
            busy       <= 1'b0;
            load_ready <= 1'b1;
          end else if (start && (((state == IDLE) && (count != '0)) ||
                                 ((state == DONE) && (reload_reg != '0)))) begin
            // From DONE the count restarts from the stored reload value
            if (state == DONE) begin
              count <= reload_reg;
            end
            mode_reg   <= auto_reload;
            state      <= RUN;
            done       <= 1'b0;
            busy       <= 1'b1;
            load_ready <= 1'b0;
`ifdef DOWN_TIMER_PRESCALE_EN
            presc      <= '0;
`endif
          end
        end

        RUN: begin
          if (abort) begin
            count      <= reload_reg;
            state      <= IDLE;
            busy       <= 1'b0;
            load_ready <= 1'b1;
`ifdef DOWN_TIMER_PRESCALE_EN
            presc      <= '0;
`endif
          end else if (pause) begin
            // Enter HOLD without consuming a decrement or prescaler step
            state <= HOLD;
          end else if (tick) begin
`ifdef DOWN_TIMER_PRESCALE_EN
            presc <= '0;
`endif
            if (count > WIDTH'(1)) begin
              count <= count - WIDTH'(1);
            end else if (mode_reg) begin
              count <= reload_reg;
              tc    <= 1'b1;
            end else begin
              // Terminal count in one-shot mode; count saturates at zero
              count      <= '0;
              tc         <= 1'b1;
              state      <= DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              load_ready <= 1'b1;
            end
          end else begin
`ifdef DOWN_TIMER_PRESCALE_EN
            presc <= presc + PW'(1);
`endif
          end
        end

        HOLD: begin
          if (abort) begin
            count      <= reload_reg;
            state      <= IDLE;
            busy       <= 1'b0;
            load_ready <= 1'b1;
`ifdef DOWN_TIMER_PRESCALE_EN
            presc      <= '0;
`endif
          end else if (!pause) begin
            // Resume; the next decrement happens on a later edge
            state <= RUN;
          end
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
